// File: rtl/calc_pkg.sv
// Shared encodings for the calculator datapath and its control unit.
package calc_pkg;

  localparam int unsigned NREG   = 4;
  localparam int unsigned ADDR_W = 2;

  // Write-data select (s1)
  localparam logic [1:0] S1_RES  = 2'b00;
  localparam logic [1:0] S1_ZERO = 2'b01;
  localparam logic [1:0] S1_IN2  = 2'b10;
  localparam logic [1:0] S1_IN1  = 2'b11;

  // ALU operation (c)
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_XOR = 2'b11;

endpackage

// File: rtl/calc_rf.sv
// Register file: two gated combinational read ports, one write port, sync clear.
module calc_rf
  import calc_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned NREG  = calc_pkg::NREG
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [1:0]        wa,
  input  logic [WIDTH-1:0]  wd,
  input  logic [1:0]        raa,
  input  logic              rea,
  input  logic [1:0]        rab,
  input  logic              reb,
  output logic [WIDTH-1:0]  rda,
  output logic [WIDTH-1:0]  rdb
);

  logic [WIDTH-1:0] regs [NREG];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NREG); i++) regs[i] <= '0;
    end else if (we) begin
      regs[wa] <= wd;
    end
  end

  // Reads see the pre-edge contents; there is deliberately no write bypass.
  assign rda = rea ? regs[raa] : '0;
  assign rdb = reb ? regs[rab] : '0;

endmodule

// File: rtl/calc_dp.sv
// Calculator datapath: register file, ALU, write/result muxes, output register.
// Define CALC_DP_FLAGS_EN to add the carry_f / ovf_f status outputs.
module calc_dp
  import calc_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned NREG  = calc_pkg::NREG
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  in1,
  input  logic [WIDTH-1:0]  in2,
  input  logic [1:0]        s1,
  input  logic [1:0]        wa,
  input  logic              we,
  input  logic [1:0]        raa,
  input  logic              rea,
  input  logic [1:0]        rab,
  input  logic              reb,
  input  logic [1:0]        c,
  input  logic              s2,
  input  logic              done,
  output logic [WIDTH-1:0]  out,
  output logic              out_valid,
  output logic              zero_f
`ifdef CALC_DP_FLAGS_EN
  ,
  output logic              carry_f,
  output logic              ovf_f
`endif
);

  logic [WIDTH-1:0] rda;
  logic [WIDTH-1:0] rdb;
  logic [WIDTH-1:0] wd;
  logic [WIDTH-1:0] alu_res;
  logic             alu_carry;
  logic             alu_ovf;

  calc_rf #(.WIDTH(WIDTH), .NREG(NREG)) u_rf (
    .clk (clk),
    .rst (rst),
    .we  (we),
    .wa  (wa),
    .wd  (wd),
    .raa (raa),
    .rea (rea),
    .rab (rab),
    .reb (reb),
    .rda (rda),
    .rdb (rdb)
  );

  // ALU; carry is the carry-out for add and the borrow for sub.
  always_comb begin
    alu_res   = '0;
    alu_carry = 1'b0;
    alu_ovf   = 1'b0;
    case (c)
      OP_ADD: begin
        {alu_carry, alu_res} = {1'b0, rda} + {1'b0, rdb};
        alu_ovf = (rda[WIDTH-1] == rdb[WIDTH-1]) && (alu_res[WIDTH-1] != rda[WIDTH-1]);
      end
      OP_SUB: begin
        {alu_carry, alu_res} = {1'b0, rda} - {1'b0, rdb};
        alu_ovf = (rda[WIDTH-1] != rdb[WIDTH-1]) && (alu_res[WIDTH-1] != rda[WIDTH-1]);
      end
      OP_AND:  alu_res = rda & rdb;
      default: alu_res = rda ^ rdb;
    endcase
  end

  always_comb begin
    wd = '0;
    case (s1)
      S1_IN1:  wd = in1;
      S1_IN2:  wd = in2;
      S1_ZERO: wd = '0;
      default: wd = alu_res;
    endcase
  end

`ifndef CALC_DP_FLAGS_EN
  logic unused_flags;
  assign unused_flags = alu_carry ^ alu_ovf;
`endif

  // Status flags track ALU write-backs only; out_valid drops on a write without capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      out       <= '0;
      out_valid <= 1'b0;
      zero_f    <= 1'b0;
`ifdef CALC_DP_FLAGS_EN
      carry_f   <= 1'b0;
      ovf_f     <= 1'b0;
`endif
    end else begin
      if (we && (s1 == S1_RES)) begin
        zero_f  <= (alu_res == '0);
`ifdef CALC_DP_FLAGS_EN
        carry_f <= alu_carry;
        ovf_f   <= alu_ovf;
`endif
      end
      if (done) begin
        out       <= s2 ? '0 : rda;
        out_valid <= 1'b1;
      end else if (we) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_calc_dp.sv
// Self-checking bench for calc_dp (WIDTH=4): directed vector table plus a
// randomized run against a behavioural model.
module tb_calc_dp;

  logic       clk = 1'b0;
  logic       rst, we, rea, reb, s2, done;
  logic [3:0] in1, in2, out;
  logic [1:0] s1, wa, raa, rab, c;
  logic       out_valid, zero_f;
`ifdef CALC_DP_FLAGS_EN
  logic       carry_f, ovf_f;
`endif

  always #5 clk = ~clk;

  calc_dp #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .in1(in1), .in2(in2), .s1(s1), .wa(wa), .we(we),
    .raa(raa), .rea(rea), .rab(rab), .reb(reb), .c(c), .s2(s2), .done(done),
    .out(out), .out_valid(out_valid), .zero_f(zero_f)
`ifdef CALC_DP_FLAGS_EN
    , .carry_f(carry_f), .ovf_f(ovf_f)
`endif
  );

  typedef struct {
    logic       rst;
    logic [3:0] in1, in2;
    logic [1:0] s1, wa;
    logic       we;
    logic [1:0] raa;
    logic       rea;
    logic [1:0] rab;
    logic       reb;
    logic [1:0] c;
    logic       s2, done;
    logic [3:0] e_out;
    logic       e_ov, e_zf, e_cf, e_vf;
  } vec_t;

  int n_total = 0;
  int n_pass  = 0;

  function automatic vec_t v(input logic r, input int i1, input int i2, input int sel,
                             input int a_w, input logic w, input int a_a, input logic ea,
                             input int a_b, input logic eb, input int op, input logic z,
                             input logic d, input int eo, input logic eov, input logic ezf,
                             input logic ecf, input logic evf);
    vec_t t;
    t.rst = r; t.in1 = 4'(i1); t.in2 = 4'(i2); t.s1 = 2'(sel); t.wa = 2'(a_w);
    t.we = w; t.raa = 2'(a_a); t.rea = ea; t.rab = 2'(a_b); t.reb = eb;
    t.c = 2'(op); t.s2 = z; t.done = d; t.e_out = 4'(eo); t.e_ov = eov;
    t.e_zf = ezf; t.e_cf = ecf; t.e_vf = evf;
    return t;
  endfunction

  task automatic chk(input string name, input int got, input int want);
    n_total++;
    if (got == want) n_pass++;
    else $display("FAIL %s got=%0d want=%0d", name, got, want);
  endtask

  // Drive one cycle on the falling edge, check registered outputs just after the rising edge.
  task automatic apply(input vec_t t, input string tag);
    @(negedge clk);
    rst = t.rst; in1 = t.in1; in2 = t.in2; s1 = t.s1; wa = t.wa; we = t.we;
    raa = t.raa; rea = t.rea; rab = t.rab; reb = t.reb; c = t.c; s2 = t.s2; done = t.done;
    @(posedge clk);
    #1;
    chk({tag, ".out"}, int'(out), int'(t.e_out));
    chk({tag, ".out_valid"}, int'(out_valid), int'(t.e_ov));
    chk({tag, ".zero_f"}, int'(zero_f), int'(t.e_zf));
`ifdef CALC_DP_FLAGS_EN
    chk({tag, ".carry_f"}, int'(carry_f), int'(t.e_cf));
    chk({tag, ".ovf_f"}, int'(ovf_f), int'(t.e_vf));
`endif
  endtask

  // Behavioural reference model state
  int m_r [4];
  int m_out, m_ov, m_zf, m_cf, m_vf;

  function automatic int sgn(input int x);
    return (x > 7) ? x - 16 : x;
  endfunction

  task automatic model_step(input vec_t i, output vec_t o);
    int a, b, res, cf, vf, wdat, sr;
    o = i;
    a = i.rea ? m_r[i.raa] : 0;
    b = i.reb ? m_r[i.rab] : 0;
    cf = 0; vf = 0;
    case (i.c)
      2'd0: begin res = (a + b) % 16; cf = (a + b > 15); sr = sgn(a) + sgn(b); vf = (sr > 7 || sr < -8); end
      2'd1: begin res = (a - b + 16) % 16; cf = (a < b); sr = sgn(a) - sgn(b); vf = (sr > 7 || sr < -8); end
      2'd2: res = a & b;
      default: res = a ^ b;
    endcase
    case (i.s1)
      2'd3: wdat = i.in1;
      2'd2: wdat = i.in2;
      2'd1: wdat = 0;
      default: wdat = res;
    endcase
    if (i.rst) begin
      for (int k = 0; k < 4; k++) m_r[k] = 0;
      m_out = 0; m_ov = 0; m_zf = 0; m_cf = 0; m_vf = 0;
    end else begin
      if (i.we) begin
        m_r[i.wa] = wdat;
        if (i.s1 == 2'd0) begin m_zf = (res == 0); m_cf = cf; m_vf = vf; end
      end
      if (i.done) begin m_out = i.s2 ? 0 : a; m_ov = 1; end
      else if (i.we) m_ov = 0;
    end
    o.e_out = 4'(m_out); o.e_ov = 1'(m_ov); o.e_zf = 1'(m_zf);
    o.e_cf = 1'(m_cf); o.e_vf = 1'(m_vf);
  endtask

  vec_t tbl [$];

  initial begin
    vec_t t, e;
    rst = 1'b1; in1 = '0; in2 = '0; s1 = '0; wa = '0; we = 1'b0;
    raa = '0; rea = 1'b0; rab = '0; reb = 1'b0; c = '0; s2 = 1'b0; done = 1'b0;

    // Reset state, then add / sub / xor / read-disable / done+we cases.
    tbl.push_back(v(1,0,0,0,0,0, 0,0,0,0,0,0,0,  0,0,0,0,0));
    tbl.push_back(v(0,5,0,3,1,1, 0,0,0,0,0,0,0,  0,0,0,0,0));
    tbl.push_back(v(0,0,3,2,2,1, 0,0,0,0,0,0,0,  0,0,0,0,0));
    tbl.push_back(v(0,0,0,0,3,1, 1,1,2,1,0,0,0,  0,0,0,0,1));
    tbl.push_back(v(0,0,0,0,0,0, 3,1,0,0,0,0,1,  8,1,0,0,1));
    tbl.push_back(v(0,3,0,3,1,1, 0,0,0,0,0,0,0,  8,0,0,0,1));
    tbl.push_back(v(0,0,5,2,2,1, 0,0,0,0,0,0,0,  8,0,0,0,1));
    tbl.push_back(v(0,0,0,0,3,1, 1,1,2,1,1,0,0,  8,0,0,1,0));
    tbl.push_back(v(0,0,0,0,0,0, 3,1,0,0,0,0,1, 14,1,0,1,0));
    tbl.push_back(v(0,7,0,3,1,1, 0,0,0,0,0,0,0, 14,0,0,1,0));
    tbl.push_back(v(0,0,7,2,2,1, 0,0,0,0,0,0,0, 14,0,0,1,0));
    tbl.push_back(v(0,0,0,0,3,1, 1,1,2,1,3,0,0, 14,0,1,0,0));
    tbl.push_back(v(0,0,0,0,0,0, 3,1,0,0,0,1,1,  0,1,1,0,0));
    tbl.push_back(v(0,9,0,3,1,1, 0,0,0,0,0,0,0,  0,0,1,0,0));
    tbl.push_back(v(0,0,0,0,3,1, 1,0,2,0,0,0,0,  0,0,1,0,0));
    tbl.push_back(v(0,0,0,0,0,0, 1,1,0,0,0,0,1,  9,1,1,0,0));
    tbl.push_back(v(0,0,0,0,0,0, 3,1,0,0,0,0,1,  0,1,1,0,0));
    tbl.push_back(v(0,0,0,0,0,0, 1,0,0,0,0,0,1,  0,1,1,0,0));
    tbl.push_back(v(0,4,0,3,1,1, 1,1,0,0,0,0,1,  9,1,1,0,0));
    tbl.push_back(v(0,0,0,0,0,0, 1,1,0,0,0,0,1,  4,1,1,0,0));
    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("vec%0d", i));

    // Same-cycle write/read of R1: the capture sees the old value, the next read the new one.
    apply(v(0,5,0,3,1,1, 0,0,0,0,0,0,0, 4,0,1,0,0), "coll_set");
    apply(v(0,9,0,3,1,1, 1,1,0,0,0,0,1, 5,1,1,0,0), "coll_old");
    apply(v(0,0,0,0,0,0, 1,1,0,0,0,0,1, 9,1,1,0,0), "coll_new");

    // Reset landing on an ALU write with done: nothing is written, everything clears.
    apply(v(0,0,0,0,3,1, 1,1,2,1,3,0,0, 9,0,0,0,0), "rst_prep");
    apply(v(0,0,0,0,0,0, 3,1,0,0,0,0,1, 14,1,0,0,0), "rst_prep_rd");
    apply(v(1,0,0,0,3,1, 1,1,2,1,0,0,1, 0,0,0,0,0), "rst_mid");
    apply(v(0,6,0,3,0,1, 0,0,0,0,0,0,0, 0,0,0,0,0), "rst_we");
    apply(v(0,0,0,0,0,0, 3,1,0,0,0,0,1, 0,1,0,0,0), "rst_r3");
    apply(v(0,0,0,0,0,0, 1,1,0,0,0,0,1, 0,1,0,0,0), "rst_r1");

    // Randomized run against the model, starting from a known reset.
    t = v(1,0,0,0,0,0, 0,0,0,0,0,0,0, 0,0,0,0,0);
    model_step(t, e);
    apply(e, "rnd_rst");
    for (int n = 0; n < 400; n++) begin
      t.rst  = ($urandom_range(0, 31) == 0);
      t.in1  = 4'($urandom); t.in2 = 4'($urandom);
      t.s1   = 2'($urandom); t.wa  = 2'($urandom);
      t.we   = ($urandom_range(0, 3) != 0);
      t.raa  = 2'($urandom); t.rea = ($urandom_range(0, 7) != 0);
      t.rab  = 2'($urandom); t.reb = ($urandom_range(0, 7) != 0);
      t.c    = 2'($urandom); t.s2  = ($urandom_range(0, 3) == 0);
      t.done = ($urandom_range(0, 2) == 0);
      model_step(t, e);
      apply(e, $sformatf("rnd%0d", n));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/calc_dp.md
CALC_DP -- requirements
Module: calc_dp

Interface
REQ-001 SHALL have parameter WIDTH, default 4, data width of operands, registers and result.
REQ-002 SHALL have parameter NREG, fixed at 4, register-file depth; it SHALL be addressed by the 2-bit wa/raa/rab.
REQ-003 SHALL have port clk, input, 1, rising-edge clock for all state.
REQ-004 SHALL have port rst, input, 1, reset: synchronous, active-high.
REQ-005 SHALL have port in1, input, WIDTH, first operand from the operator.
REQ-006 SHALL have port in2, input, WIDTH, second operand from the operator.
REQ-007 SHALL have port s1, input, 2, write-data select: 11=in1, 10=in2, 01=zero, 00=ALU result.
REQ-008 SHALL have ports wa/we, input, 2/1, write address and write enable.
REQ-009 SHALL have ports raa/rea and rab/reb, input, 2/1 each, read addresses and enables for ports A and B.
REQ-010 SHALL have port c, input, 2, ALU op: 00=A+B, 01=A-B, 10=A&B, 11=A^B.
REQ-011 SHALL have port s2, input, 1, result select: 0=port A data, 1=zero.
REQ-012 SHALL have port done, input, 1, capture strobe from the control unit.
REQ-013 SHALL have port out, output, WIDTH, registered result.
REQ-014 SHALL have port out_valid, output, 1, result-held flag.
REQ-015 SHALL have port zero_f, output, 1, registered flag: last ALU write was zero.

Function
REQ-016 The register file SHALL write the s1-selected data to R[wa] on a clock edge where we=1.
REQ-017 Read port A SHALL equal R[raa] combinationally when rea=1 and zero when rea=0; port B likewise with rab/reb.
REQ-018 Same-cycle write and read of one address SHALL return the old value, with no bypass.
REQ-019 The ALU SHALL be combinational on port A/B data; add and sub SHALL wrap modulo 2^WIDTH.
REQ-020 zero_f SHALL update only on edges where we=1 and s1=00, taking the value (ALU result==0).
REQ-021 On an edge with done=1, out SHALL load (s2 ? 0 : port A data) and out_valid SHALL set to 1.
REQ-022 out_valid SHALL clear on any edge with we=1 and done=0; out SHALL hold its value.
REQ-023 done=1 and we=1 in the same cycle SHALL capture out, set out_valid, and perform the write.
REQ-024 All outputs SHALL be registered, with no combinational path from inputs to outputs.

Reset
REQ-025 rst=1 at a clock edge SHALL clear R0-R3, out, out_valid, zero_f (and the REQ-027 flags) to 0.
REQ-026 rst SHALL take priority over we and done in the same cycle, including mid-sequence; no write SHALL occur.

Configuration
REQ-027 With macro CALC_DP_FLAGS_EN defined, outputs carry_f and ovf_f SHALL exist.
REQ-028 carry_f and ovf_f SHALL update with zero_f: carry_f = carry-out for add or borrow for sub, 0 for and/xor; ovf_f = signed overflow for add/sub, 0 otherwise.
REQ-029 Without CALC_DP_FLAGS_EN, those ports and their logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-030 A shared package calc_pkg SHALL hold the s1 and c encodings as named constants and the NREG constant; the control unit SHALL use the same package.
REQ-031 The register file SHALL be a sub-module calc_rf (2 read ports, 1 write port, synchronous clear); the muxes, ALU and output register SHALL be in calc_dp.

Verification (WIDTH=4)
REQ-032 Add case: in1=5, s1=11, wa=01, we=1; in2=3, s1=10, wa=10; raa=01, rab=10, rea=reb=1, c=00, s1=00, wa=11, we=1; done=1, raa=11 -> out=8, out_valid=1, zero_f=0.
REQ-033 Subtract case: operands 3 and 5, c=01 -> R3=0xE, out=0xE; with the flags macro, carry_f=1 and ovf_f=0.
REQ-034 Xor case: operands 7 and 7, c=11 -> R3=0, zero_f=1; the following done cycle with s2=1 -> out=0.
REQ-035 Read-disable case: rea=reb=0, c=00, write to R3 -> R3=0 regardless of stored values.
REQ-036 Collision case: write R1=9 while raa=01 reads the old value 5 in the same cycle -> ALU sees 5; the next cycle reads 9.
REQ-037 Reset case: rst=1 in the cycle of the ALU write -> R3, out, out_valid and flags are all 0 afterwards; a subsequent we=1 without done keeps out_valid=0.
